// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM generator.
// Counter width, the default dead-time length and the idle output level.
package pwm_pkg;

    localparam int CNT_W           = 8;
    localparam int DEAD_CYCLES_DEF = 2;

    function automatic logic inactive_level(input logic active_high);
        return ~active_high;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion: both outputs forced inactive for DEAD_CYCLES clocks
// after every change of the raw compare result.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter bit ACTIVE_HIGH = 1'b1,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pwm_out,
    output logic pwm_n_out
);

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES);

    logic       raw_prev;
    logic [3:0] dt_cnt;
    logic [3:0] dt_next;
    logic       level;

    assign level = raw ~^ ACTIVE_HIGH;

    // A raw edge during an active gap reloads the counter.
    always_comb begin
        dt_next = dt_cnt;
        if (raw != raw_prev) begin
            dt_next = DEAD_LOAD;
        end else if (dt_cnt != 4'd0) begin
            dt_next = dt_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_prev  <= 1'b0;
            dt_cnt    <= 4'd0;
            pwm_out   <= inactive_level(ACTIVE_HIGH);
            pwm_n_out <= 1'b0;
        end else begin
            raw_prev <= raw;
            dt_cnt   <= dt_next;
            if (dt_next != 4'd0) begin
                pwm_out   <= inactive_level(ACTIVE_HIGH);
                pwm_n_out <= 1'b0;
            end else begin
                pwm_out   <= level;
                pwm_n_out <= ~level;
            end
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator fed by a free-running counter, with double-buffered duty.
// Optional dead-time insertion is enabled by defining PWM_DEADTIME_EN.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH       = CNT_W,
    parameter bit ACTIVE_HIGH = 1'b1,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_wr,
    output logic             duty_pending,
    output logic             period_done,
    output logic             pwm_out,
    output logic             pwm_n_out
);

    logic [WIDTH-1:0] cnt_prev;
    logic [WIDTH-1:0] duty_shadow;
    logic [WIDTH-1:0] duty_active;
    logic             boundary;
    logic             raw;

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : g_dead_range
        $error("pwm_gen: DEAD_CYCLES must be in 1..15");
    end

    // A counter parked at zero yields a single boundary, not one per cycle.
    assign boundary = (cnt_in == '0) && (cnt_prev != '0);
    assign raw      = (cnt_in < duty_active);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_prev     <= '0;
            duty_shadow  <= '0;
            duty_active  <= '0;
            duty_pending <= 1'b0;
            period_done  <= 1'b0;
        end else begin
            cnt_prev    <= cnt_in;
            period_done <= boundary;
            if (boundary && duty_pending) begin
                duty_active  <= duty_shadow;
                duty_pending <= 1'b0;
            end
            // A write coinciding with the boundary lands after the apply.
            if (duty_wr) begin
                duty_shadow  <= duty_in;
                duty_pending <= 1'b1;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
        .ACTIVE_HIGH (ACTIVE_HIGH),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_deadtime (
        .clk       (clk),
        .rst       (rst),
        .raw       (raw),
        .pwm_out   (pwm_out),
        .pwm_n_out (pwm_n_out)
    );
`else
    logic level;

    assign level = raw ~^ ACTIVE_HIGH;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out   <= inactive_level(ACTIVE_HIGH);
            pwm_n_out <= 1'b0;
        end else begin
            pwm_out   <= level;
            pwm_n_out <= ~level;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: per-cycle scoreboard plus per-period
// high-time and period-marker counts.
module tb_pwm_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cnt_in = 8'd0;
    logic [7:0] duty_in = 8'd0;
    logic       duty_wr = 1'b0;
    logic       duty_pending;
    logic       period_done;
    logic       pwm_out;
    logic       pwm_n_out;

    pwm_gen dut (
        .clk          (clk),
        .rst          (rst),
        .cnt_in       (cnt_in),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .duty_pending (duty_pending),
        .period_done  (period_done),
        .pwm_out      (pwm_out),
        .pwm_n_out    (pwm_n_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int high_acc = 0;
    int pd_acc = 0;

    logic [3:0] exp_q[$];

    // reference state
    logic [7:0] m_prev, m_shadow, m_active;
    logic       m_pend;
    logic       m_raw_prev;
    int         m_dt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] c, input logic w, input logic [7:0] d);
        logic       bnd;
        logic       lvl;
        logic       pw;
        logic       pn;
        logic [3:0] got;
        rst     = r;
        cnt_in  = c;
        duty_wr = w;
        duty_in = d;
        if (r) begin
            m_prev = 8'd0; m_shadow = 8'd0; m_active = 8'd0; m_pend = 1'b0;
            m_raw_prev = 1'b0; m_dt = 0;
            exp_q.push_back(4'b0000);
        end else begin
            bnd = (c == 8'd0) && (m_prev != 8'd0);
            lvl = (c < m_active);
`ifdef PWM_DEADTIME_EN
            if (lvl != m_raw_prev) m_dt = 2;
            else if (m_dt > 0) m_dt = m_dt - 1;
            m_raw_prev = lvl;
            pw = (m_dt == 0) ? lvl : 1'b0;
            pn = (m_dt == 0) ? ~lvl : 1'b0;
`else
            pw = lvl;
            pn = ~lvl;
`endif
            if (bnd && m_pend) begin
                m_active = m_shadow;
                m_pend   = 1'b0;
            end
            if (w) begin
                m_shadow = d;
                m_pend   = 1'b1;
            end
            m_prev = c;
            exp_q.push_back({m_pend, bnd, pw, pn});
        end
        @(posedge clk);
        #1;
        got = {duty_pending, period_done, pwm_out, pwm_n_out};
        check("outs", 32'(got), 32'(exp_q.pop_front()));
        check("overlap", 32'(pwm_out & pwm_n_out), 32'd0);
        if (pwm_out) high_acc++;
        if (period_done) pd_acc++;
    endtask

    // One full counter sweep 0..255 with up to two writes at chosen counts.
    task automatic sweep(input int wa, input logic [7:0] va, input int wb, input logic [7:0] vb);
        high_acc = 0;
        pd_acc   = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, i[7:0], (i == wa) || (i == wb), (i == wb) ? vb : va);
        end
    endtask

    task automatic check_high(input string tag, input int exp);
`ifndef PWM_DEADTIME_EN
        check(tag, 32'(high_acc), 32'(exp));
`else
        if (exp < 0) check(tag, 32'(high_acc), 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 8'd0, 1'b0, 8'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_pwm_n", 32'(pwm_n_out), 32'd0);
        check("rst_pend", 32'(duty_pending), 32'd0);

        // idle: no duty, one marker per period once wrapping
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("idle_high0", 0);
        check("idle_pd0", 32'(pd_acc), 32'd0);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("idle_high1", 0);
        check("idle_pd1", 32'(pd_acc), 32'd1);

        // duty 64 written mid-period
        sweep(100, 8'd64, -1, 8'd0);
        check_high("d64_wr", 0);
        check("d64_pend", 32'(duty_pending), 32'd1);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("d64_first", 63);
        check("d64_clr", 32'(duty_pending), 32'd0);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("d64_steady", 64);
        check("d64_pd", 32'(pd_acc), 32'd1);

        // last write wins
        sweep(10, 8'd32, 150, 8'd200);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("d200_first", 200);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("d200_steady", 200);

        // extremes
        sweep(5, 8'd0, -1, 8'd0);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("d0_first", 1);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("d0_steady", 0);
        sweep(5, 8'd255, -1, 8'd0);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("d255_first", 254);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("d255_steady", 255);

        // write on the boundary cycle applies the old shadow
        sweep(20, 8'd50, -1, 8'd0);
        sweep(0, 8'd10, -1, 8'd0);
        check_high("bnd_wr_old", 50);
        check("bnd_wr_pend", 32'(duty_pending), 32'd1);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("bnd_wr_new", 10);

        // counter held in reset mid-period
        for (int i = 0; i < 100; i++) step(1'b0, i[7:0], i == 30, 8'd77);
        high_acc = 0;
        pd_acc   = 0;
        for (int i = 0; i < 11; i++) step(1'b0, 8'd0, 1'b0, 8'd0);
        check("hold_pd", 32'(pd_acc), 32'd1);
        check_high("hold_high", 11);
        high_acc = 0;
        for (int i = 1; i < 256; i++) step(1'b0, i[7:0], 1'b0, 8'd0);
        check_high("hold_after", 76);

        // reset mid-operation discards pending shadow
        for (int i = 0; i < 50; i++) step(1'b0, i[7:0], i == 10, 8'd123);
        step(1'b1, 8'd50, 1'b0, 8'd0);
        step(1'b1, 8'd51, 1'b0, 8'd0);
        check("mid_rst_pend", 32'(duty_pending), 32'd0);
        sweep(-1, 8'd0, -1, 8'd0);
        sweep(-1, 8'd0, -1, 8'd0);
        check_high("mid_rst_high", 0);

        // random writes, checked cycle by cycle
        for (int k = 0; k < 4; k++) begin
            sweep($urandom_range(0, 255), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 255), 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
